// File: rtl/adder_arbiter.sv
// ---------------------------------------------------------------------------
// adder_arbiter
//
// Round-robin arbiter that shares one external combinational WIDTH-bit adder
// among N_REQ requesters. Each cycle it picks at most one requester, steers
// that requester's operands onto the adder, and captures the adder's sum in
// a single result register. The register is tagged with the requester ID
// and drained through a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req_valid  per-requester operation request
//   req_a      packed operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      packed operand B, same packing
//   req_ready  one-hot accept strobe (at most one bit high)
//   add_a      operand A to the shared adder
//   add_b      operand B to the shared adder
//   add_out    sum returned by the shared adder (combinational)
//   res_valid  result register holds a valid sum
//   res_data   registered sum
//   res_id     index of the requester that produced res_data
//   res_ready  consumer accepts the result
//   op_count   number of accepted operations, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module adder_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 32,
   parameter int ID_W  = 2,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic [N_REQ-1:0]       req_ready,
   output logic [WIDTH-1:0]       add_a,
   output logic [WIDTH-1:0]       add_b,
   input  logic [WIDTH-1:0]       add_out,
   output logic                   res_valid,
   output logic [WIDTH-1:0]       res_data,
   output logic [ID_W-1:0]        res_id,
   input  logic                   res_ready,
   output logic [CNT_W-1:0]       op_count
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_REQ - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] res_data_q, res_data_d;
   logic [ID_W-1:0]  res_id_q, res_id_d;
   logic [ID_W-1:0]  last_q, last_d;
   logic [CNT_W-1:0] op_count_q, op_count_d;

   logic             slot_free;
   logic             grant_found;
   logic [ID_W-1:0]  grant_idx;
   logic             accept;
   int               cand;

   // The result slot can take a new sum when it is empty or being drained
   // this cycle. Reset also blocks grants so req_ready is low while rst=1.
   assign slot_free = ((state_q == EMPTY) || res_ready) && !rst;

   // Round-robin search starting just after the last accepted requester.
   // The first hit wins; later hits are ignored by the grant_found guard.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      if (slot_free) begin
         for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last_q) + k) % N_REQ;
            if (!grant_found && req_valid[ID_W'(cand)]) begin
               grant_found = 1'b1;
               grant_idx   = ID_W'(cand);
            end
         end
      end
   end

   // One-hot ready and operand steering follow the grant in the same cycle.
   // With no grant the adder inputs are parked at zero.
   always_comb begin
      req_ready = '0;
      add_a     = '0;
      add_b     = '0;
      if (grant_found) begin
         req_ready = N_REQ'(1) << grant_idx;
         add_a     = req_a[grant_idx*WIDTH +: WIDTH];
         add_b     = req_b[grant_idx*WIDTH +: WIDTH];
      end
   end

   assign accept = |(req_valid & req_ready);

   // Next-state logic: an accept always (re)fills the slot, which also
   // covers the back-to-back case where the old result drains as the new
   // one lands. A drain with no accept empties the slot.
   always_comb begin
      state_d    = state_q;
      res_data_d = res_data_q;
      res_id_d   = res_id_q;
      last_d     = last_q;
      op_count_d = op_count_q;
      if (accept) begin
         state_d    = FULL;
         res_data_d = add_out;
         res_id_d   = grant_idx;
         last_d     = grant_idx;
         op_count_d = op_count_q + 1'b1;
      end else if ((state_q == FULL) && res_ready) begin
         state_d = EMPTY;
      end
   end

   // State and result registers. Reset drops any held result and points
   // the round-robin pointer at the last index so requester 0 goes first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= EMPTY;
         res_data_q <= '0;
         res_id_q   <= '0;
         last_q     <= LAST_RST;
         op_count_q <= '0;
      end else begin
         state_q    <= state_d;
         res_data_q <= res_data_d;
         res_id_q   <= res_id_d;
         last_q     <= last_d;
         op_count_q <= op_count_d;
      end
   end

   assign res_valid = (state_q == FULL);
   assign res_data  = res_data_q;
   assign res_id    = res_id_q;
   assign op_count  = op_count_q;

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
Round-robin arbiter and sequencer that shares one external 32-bit combinational adder (ports a, b, out) among N_REQ requesters. It selects one requester per cycle and steers that requester's operands onto the adder. The sum is captured in a single output register with a valid/ready handshake, tagged with the requester ID. It sits between the requesting units and the shared adder instance.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIDTH, 32, operand/result width; must match the adder
ID_W, 2, requester ID width; equals clog2(N_REQ)
CNT_W, 16, width of completed-operation counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req_valid  input  N_REQ  per-requester operation request
req_a  input  N_REQ*WIDTH  packed operand A; requester i at bits [i*WIDTH +: WIDTH]
req_b  input  N_REQ*WIDTH  packed operand B, same packing
req_ready  output  N_REQ  one-hot accept strobe; at most one bit high
add_a  output  WIDTH  to shared adder input a
add_b  output  WIDTH  to shared adder input b
add_out  input  WIDTH  from shared adder output out (combinational)
res_valid  output  1  result register holds a valid sum
res_data  output  WIDTH  registered sum
res_id  output  ID_W  index of the requester that produced res_data
res_ready  input  1  consumer accepts result
op_count  output  CNT_W  number of accepted operations, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, rst=1): res_valid=0, res_data=0, res_id=0, op_count=0, round-robin pointer last=N_REQ-1, so requester 0 has top priority after reset. req_ready=0 while rst=1. Reset mid-operation discards any held result; there is no pending state to recover.
- Two-state FSM on res_valid: EMPTY (res_valid=0), FULL (res_valid=1).
- slot_free = !res_valid | res_ready.
- Grant (combinational): when slot_free, search req_valid starting at index (last+1) mod N_REQ, wrapping. The first asserted index g is granted and req_ready[g]=1. No request or !slot_free gives req_ready=0.
- Steering: on a grant, add_a/add_b = req_a/req_b slice g in the same cycle. With no grant, add_a=add_b=0.
- Accept = req_valid[g] & req_ready[g]. On the next clock edge: res_data<=add_out, res_id<=g, res_valid<=1, last<=g, op_count<=op_count+1.
- Latency: accept in cycle T gives res_valid=1 in cycle T+1. Throughput is 1 operation per cycle when res_ready is held at 1.
- EMPTY->FULL on accept. FULL->EMPTY on res_ready with no accept. FULL->FULL on res_ready plus a simultaneous accept (back-to-back; new result replaces old). With res_ready=0 in FULL, all outputs stay held and req_ready=0.
- The pointer advances only on accept. A continuously requesting input waits at most N_REQ-1 grants.
- Arithmetic: modular WIDTH-bit sum, no carry or overflow reported. 0xFFFFFFFF+1 = 0.
- op_count wraps from 2^CNT_W-1 to 0.
- Upstream rule: a requester holds req_a/req_b stable while req_valid=1 and its req_ready=0. Dropping req_valid before a grant is legal; the request is simply lost.
- req_ready must never be high for an index whose req_valid is low.

Test Plan:
1. Assert rst during activity -> res_valid=0, res_data=0, op_count=0, req_ready=0 immediately without waiting for a clock edge. Release rst, then raise all req_valid -> requester 0 is granted first.
2. Requester 0 only, a=0x00000001, b=0x00000002, res_ready=1 -> req_ready=4'b0001 in cycle T. In T+1: res_valid=1, res_data=0x00000003, res_id=0, op_count=1.
3. All four valid continuously, res_ready=1 -> req_ready sequence 0001, 0010, 0100, 1000, 0001. res_id sequence one cycle later is 0, 1, 2, 3, 0. op_count=5 after 5 cycles.
4. Backpressure with res_valid=1 and res_ready=0 for 3 cycles -> req_ready=0, res_data and res_id held stable. Raise res_ready with requester 2 valid -> accepted the same cycle, new result next cycle with no bubble.
5. Wrap-around with requester 1, a=0xFFFFFFFF, b=0x00000001 -> res_data=0x00000000, res_id=1. Also a=0x80000000, b=0x80000000 -> 0x00000000.
6. Fairness and counter wrap: requesters 0 and 3 always valid -> grants alternate 0, 3, 0, 3. Preload op_count to 0xFFFF by issuing 65535 operations, then one more -> op_count=0x0000.
